// File: rtl/seq_detect_param_if.sv
// Symbol-stream interface for seq_detect_param.
// The source (master) drives the symbol, its qualifier, the mode and the
// clear; the detector (slave) returns hit/ans.
// Handshake: a symbol on num is consumed on any rising edge where in_valid=1;
// there is no ready, the detector accepts every qualified symbol.
// Optional macro SEQ_DETECT_MATCH_CNT_EN adds the match_cnt signal.
interface seq_detect_param_if #(
    parameter int SYM_W = 2,
    parameter int CNT_W = 8
);
    logic             clr;
    logic             in_valid;
    logic [SYM_W-1:0] num;
    logic             sticky;
    logic             hit;
    logic             ans;
`ifdef SEQ_DETECT_MATCH_CNT_EN
    logic [CNT_W-1:0] match_cnt;

    modport master (output clr, in_valid, num, sticky, input hit, ans, match_cnt);
    modport slave  (input clr, in_valid, num, sticky, output hit, ans, match_cnt);
`else
    modport master (output clr, in_valid, num, sticky, input hit, ans);
    modport slave  (input clr, in_valid, num, sticky, output hit, ans);
`endif

    // Reject nonsensical widths at elaboration.
    if (SYM_W < 1 || CNT_W < 1) begin : g_bad_width
        $error("seq_detect_param_if: SYM_W and CNT_W must be >= 1");
    end
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised sliding-window sequence detector.
// Detects LEN symbols of SYM_W bits matching PATTERN (first symbol in MSBs).
// Overlapping matches are found; sticky mode locks ans until clr/reset,
// pulse mode gives a one-cycle hit per match.
// Optional macro SEQ_DETECT_MATCH_CNT_EN adds a saturating match counter.
module seq_detect_param #(
    parameter int                     SYM_W   = 2,
    parameter int                     LEN     = 3,
    parameter logic [LEN*SYM_W-1:0]   PATTERN = 6'b01_10_11,
    parameter int                     CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_detect_param_if.slave     bus
);
    localparam int HW = LEN * SYM_W;
    localparam int FW = $clog2(LEN + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(LEN);

    if (SYM_W < 1 || LEN < 1 || CNT_W < 1) begin : g_bad_param
        $error("seq_detect_param: SYM_W, LEN and CNT_W must be >= 1");
    end

    logic [HW-1:0] r_hist;
    logic [FW-1:0] r_fill;
    logic          r_locked;
    logic          r_hit;
`ifdef SEQ_DETECT_MATCH_CNT_EN
    logic [CNT_W-1:0] r_cnt;
`endif

    logic [HW-1:0] w_hist_n;
    logic [FW-1:0] w_fill_n;
    logic          w_match;

    // Window after shifting in the current symbol (newest in the LSBs).
    if (LEN == 1) begin : g_hist_one
        assign w_hist_n = bus.num;
    end else begin : g_hist_many
        assign w_hist_n = {r_hist[HW-SYM_W-1:0], bus.num};
    end

    // Fill count saturates at LEN; it guards against matching a partly
    // filled window (matters when PATTERN contains zero symbols).
    assign w_fill_n = (r_fill == FILL_MAX) ? r_fill : r_fill + 1'b1;
    assign w_match  = (w_fill_n == FILL_MAX) && (w_hist_n == PATTERN);

    // Window, fill, lock and hit update: clr beats lock beats a valid symbol.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist   <= '0;
            r_fill   <= '0;
            r_locked <= 1'b0;
            r_hit    <= 1'b0;
`ifdef SEQ_DETECT_MATCH_CNT_EN
            r_cnt    <= '0;
`endif
        end else if (bus.clr) begin
            r_hist   <= '0;
            r_fill   <= '0;
            r_locked <= 1'b0;
            r_hit    <= 1'b0;
`ifdef SEQ_DETECT_MATCH_CNT_EN
            r_cnt    <= '0;
`endif
        end else if (r_locked) begin
            // Frozen until clr/reset; sticky dropping does not release it.
            r_hit <= 1'b0;
        end else if (bus.in_valid) begin
            r_hist   <= w_hist_n;
            r_fill   <= w_fill_n;
            r_hit    <= w_match;
            r_locked <= w_match & bus.sticky;
`ifdef SEQ_DETECT_MATCH_CNT_EN
            if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
`endif
        end else begin
            // Gap in the stream: keep partial progress, drop the pulse.
            r_hit <= 1'b0;
        end
    end

    assign bus.hit = r_hit;
    assign bus.ans = r_hit | r_locked;
`ifdef SEQ_DETECT_MATCH_CNT_EN
    assign bus.match_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed testbench for seq_detect_param: a default instance (LEN=3,
// PATTERN=01_10_11, CNT_W=8) and a LEN=2, PATTERN=00_00, CNT_W=2 instance.
// Counter checks are included when SEQ_DETECT_MATCH_CNT_EN is defined.
module tb_seq_detect_param;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Clock / reset
    always #5 clk = ~clk;

    seq_detect_param_if #(.SYM_W(2), .CNT_W(8)) bus_a ();
    seq_detect_param_if #(.SYM_W(2), .CNT_W(2)) bus_b ();

    seq_detect_param #(.SYM_W(2), .LEN(3), .PATTERN(6'b01_10_11), .CNT_W(8)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    seq_detect_param #(.SYM_W(2), .LEN(2), .PATTERN(4'b00_00), .CNT_W(2)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_a(input string tag, input logic eh, input logic ea);
        check({tag, ".hit"}, {31'd0, bus_a.hit}, {31'd0, eh});
        check({tag, ".ans"}, {31'd0, bus_a.ans}, {31'd0, ea});
    endtask

    // Driver tasks: called at a negedge, drive, return at the next negedge.
    task automatic step_a(input logic v, input logic [1:0] s);
        bus_a.in_valid = v;
        bus_a.num      = s;
        @(negedge clk);
        bus_a.in_valid = 1'b0;
    endtask

    task automatic step_b(input logic v, input logic [1:0] s);
        bus_b.in_valid = v;
        bus_b.num      = s;
        @(negedge clk);
        bus_b.in_valid = 1'b0;
    endtask

    task automatic clr_a();
        bus_a.clr = 1'b1;
        step_a(1'b0, 2'b00);
        bus_a.clr = 1'b0;
    endtask

    task automatic clr_b();
        bus_b.clr = 1'b1;
        step_b(1'b0, 2'b00);
        bus_b.clr = 1'b0;
    endtask

    initial begin : stimulus
        logic [1:0] s2 [7];
        logic       e2 [7];
        logic [1:0] s3 [6];
        logic       e3 [6];
        logic [1:0] ec [6];

        bus_a.clr = 1'b0; bus_a.in_valid = 1'b0; bus_a.num = 2'b00; bus_a.sticky = 1'b1;
        bus_b.clr = 1'b0; bus_b.in_valid = 1'b0; bus_b.num = 2'b00; bus_b.sticky = 1'b0;
        rst_n = 1'b0;
        #12;
        check_a("reset", 1'b0, 1'b0);
        check("reset.b.hit", {31'd0, bus_b.hit}, 32'd0);
`ifdef SEQ_DETECT_MATCH_CNT_EN
        check("reset.cnt", {24'd0, bus_a.match_cnt}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Sticky: 01,10,11 locks; later symbols ignored; clr releases.
        step_a(1'b1, 2'b01);
        step_a(1'b1, 2'b10);
        check_a("t1.e2", 1'b0, 1'b0);
        step_a(1'b1, 2'b11);
        check_a("t1.e3", 1'b1, 1'b1);
        step_a(1'b0, 2'b00);
        check_a("t1.after", 1'b0, 1'b1);
        step_a(1'b1, 2'b00);
        step_a(1'b1, 2'b01);
        check_a("t1.frozen", 1'b0, 1'b1);
        clr_a();
        check_a("t1.clr", 1'b0, 1'b0);

        // Sticky: fallback after 01,01 and break on 00; match only on edge 7.
        s2 = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b11};
        e2 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            step_a(1'b1, s2[i]);
            check_a($sformatf("t2.e%0d", i + 1), e2[i], e2[i]);
        end

        // Lock holds when sticky drops and the pattern repeats.
        bus_a.sticky = 1'b0;
        step_a(1'b1, 2'b01);
        step_a(1'b1, 2'b10);
        step_a(1'b1, 2'b11);
        check_a("hold", 1'b0, 1'b1);

        // Asynchronous reset while locked: outputs drop before any edge.
        #2 rst_n = 1'b0;
        #1 check_a("async_lock", 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Pulse mode, overlapping repeats: hits after edges 3 and 6.
        s3 = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11};
        e3 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            step_a(1'b1, s3[i]);
            check_a($sformatf("t3.e%0d", i + 1), e3[i], e3[i]);
        end
`ifdef SEQ_DETECT_MATCH_CNT_EN
        check("t3.cnt", {24'd0, bus_a.match_cnt}, 32'd2);
`endif

        // Switch pulse -> sticky between matches.
        bus_a.sticky = 1'b1;
        step_a(1'b1, 2'b01);
        step_a(1'b1, 2'b10);
        step_a(1'b1, 2'b11);
        check_a("sw.match", 1'b1, 1'b1);
        step_a(1'b0, 2'b00);
        check_a("sw.lock", 1'b0, 1'b1);
`ifdef SEQ_DETECT_MATCH_CNT_EN
        check("sw.cnt", {24'd0, bus_a.match_cnt}, 32'd3);
`endif
        clr_a();
`ifdef SEQ_DETECT_MATCH_CNT_EN
        check("sw.cnt_clr", {24'd0, bus_a.match_cnt}, 32'd0);
`endif
        bus_a.sticky = 1'b0;

        // Gaps in in_valid do not break a partial sequence.
        step_a(1'b1, 2'b01);
        repeat (5) step_a(1'b0, 2'b11);
        step_a(1'b1, 2'b10);
        repeat (2) step_a(1'b0, 2'b11);
        check_a("gap.before", 1'b0, 1'b0);
        step_a(1'b1, 2'b11);
        check_a("gap.match", 1'b1, 1'b1);
        step_a(1'b0, 2'b00);
        check_a("gap.after", 1'b0, 1'b0);
        clr_a();

        // Reset mid-sequence discards 01,10; a lone 11 then does not match.
        step_a(1'b1, 2'b01);
        step_a(1'b1, 2'b10);
        #2 rst_n = 1'b0;
        #1 check_a("async_mid", 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step_a(1'b1, 2'b11);
        check_a("mid.no_match", 1'b0, 1'b0);

        // LEN=2, PATTERN=00_00: fill guard and overlap.
        step_b(1'b1, 2'b00);
        check("b.guard1", {31'd0, bus_b.hit}, 32'd0);
        step_b(1'b1, 2'b00);
        check("b.e2", {31'd0, bus_b.hit}, 32'd1);
        step_b(1'b1, 2'b00);
        check("b.e3", {31'd0, bus_b.hit}, 32'd1);
        clr_b();
        check("b.clr", {31'd0, bus_b.hit}, 32'd0);
        step_b(1'b1, 2'b00);
        check("b.guard2", {31'd0, bus_b.hit}, 32'd0);

        // clr together with a valid symbol discards that symbol.
        bus_b.clr = 1'b1;
        step_b(1'b1, 2'b00);
        bus_b.clr = 1'b0;
        check("b.clr_valid", {31'd0, bus_b.hit}, 32'd0);
        step_b(1'b1, 2'b00);
        check("b.discard1", {31'd0, bus_b.hit}, 32'd0);
        step_b(1'b1, 2'b00);
        check("b.discard2", {31'd0, bus_b.hit}, 32'd1);

        // Five matches into a 2-bit counter saturate at 3.
        clr_b();
        ec = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 6; i++) begin
            step_b(1'b1, 2'b00);
            check($sformatf("sat.hit%0d", i + 1), {31'd0, bus_b.hit}, (i == 0) ? 32'd0 : 32'd1);
`ifdef SEQ_DETECT_MATCH_CNT_EN
            check($sformatf("sat.cnt%0d", i + 1), {30'd0, bus_b.match_cnt}, {30'd0, ec[i]});
`endif
        end

        // clr on an edge that would complete a match: clr wins.
        bus_b.clr = 1'b1;
        step_b(1'b1, 2'b00);
        bus_b.clr = 1'b0;
        check("clr_match.hit", {31'd0, bus_b.hit}, 32'd0);
`ifdef SEQ_DETECT_MATCH_CNT_EN
        check("clr_match.cnt", {30'd0, bus_b.match_cnt}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
